// File: rtl/core_pkg.sv
// Shared decode types for the ID stage: opcode values, op classes, immediate formats, ID/EX payload.
// No logic of its own; pure type and constant definitions.
// Not applicable for backpressure (package only).
package core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD_O = 7'b0000011;
    localparam logic [6:0] OPC_STORE_O = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH_O = 7'b1100011;
    localparam logic [6:0] OPC_JAL_O  = 7'b1101111;
    localparam logic [6:0] OPC_JALR_O = 7'b1100111;
    localparam logic [6:0] OPC_LUI_O  = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC_O = 7'b0010111;

    typedef enum logic [3:0] {
        OPC_ALU     = 4'd0,
        OPC_ALUI    = 4'd1,
        OPC_LOAD    = 4'd2,
        OPC_STORE   = 4'd3,
        OPC_BRANCH  = 4'd4,
        OPC_JAL     = 4'd5,
        OPC_JALR    = 4'd6,
        OPC_LUI     = 4'd7,
        OPC_AUIPC   = 4'd8,
        OPC_ILLEGAL = 4'd9
    } opclass_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        opclass_e    opclass;
        logic [3:0]  funct;
        logic        illegal;
    } idex_t;

endpackage

// File: rtl/imm_gen.sv
// Builds the sign-extended RISC-V immediate for the selected format.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// The opcode bits carry no immediate information and are deliberately ignored.
module imm_gen
    import core_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand fetch: reads the regfile, bypasses EX/MEM/WB, loads the ID/EX register.
// Latency: one cycle from accept to out_valid.
// Backpressure: in_ready drops on out stall, load-use (or any RAW without bypass) hazard, or flush.
module id_operand_stage
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_load,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_opclass,
    output logic [3:0]      out_funct,
    output logic            out_illegal
);

    function automatic logic src_hit(input logic v, input logic [4:0] rd, input logic [4:0] s);
        return v && (rd != 5'd0) && (rd == s);
    endfunction

    opclass_e    opclass;
    imm_fmt_e    fmt;
    logic        use_rs1, use_rs2, has_rd;
    logic [31:0] imm;
    logic [31:0] rs1_val, rs2_val;
    logic        hazard, load;
    idex_t       q;

    assign rf_rs1 = in_instr[19:15];
    assign rf_rs2 = in_instr[24:20];

    always_comb begin
        opclass = OPC_ILLEGAL;
        fmt     = IMM_I;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        has_rd  = 1'b0;
        case (in_instr[6:0])
            OPC_OP:       begin opclass = OPC_ALU;    use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; end
            OPC_OP_IMM:   begin opclass = OPC_ALUI;   use_rs1 = 1'b1; has_rd = 1'b1; end
            OPC_LOAD_O:   begin opclass = OPC_LOAD;   use_rs1 = 1'b1; has_rd = 1'b1; end
            OPC_STORE_O:  begin opclass = OPC_STORE;  fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_BRANCH_O: begin opclass = OPC_BRANCH; fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_JAL_O:    begin opclass = OPC_JAL;    fmt = IMM_J; has_rd = 1'b1; end
            OPC_JALR_O:   begin opclass = OPC_JALR;   use_rs1 = 1'b1; has_rd = 1'b1; end
            OPC_LUI_O:    begin opclass = OPC_LUI;    fmt = IMM_U; has_rd = 1'b1; end
            OPC_AUIPC_O:  begin opclass = OPC_AUIPC;  fmt = IMM_U; has_rd = 1'b1; end
            default:      opclass = OPC_ILLEGAL;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt),
        .imm   (imm)
    );

    // Without bypassing every RAW match stalls, so the regfile value is the only source needed.
    always_comb begin
        rs1_val = rf_rs1_data;
        rs2_val = rf_rs2_data;
        if (rf_rs1 == 5'd0)                                rs1_val = '0;
        else if (FWD_EN && src_hit(ex_valid, ex_rd, rf_rs1))   rs1_val = ex_data;
        else if (FWD_EN && src_hit(mem_valid, mem_rd, rf_rs1)) rs1_val = mem_data;
        else if (FWD_EN && src_hit(wb_write, wb_rd, rf_rs1))   rs1_val = wb_data;
        if (rf_rs2 == 5'd0)                                rs2_val = '0;
        else if (FWD_EN && src_hit(ex_valid, ex_rd, rf_rs2))   rs2_val = ex_data;
        else if (FWD_EN && src_hit(mem_valid, mem_rd, rf_rs2)) rs2_val = mem_data;
        else if (FWD_EN && src_hit(wb_write, wb_rd, rf_rs2))   rs2_val = wb_data;
    end

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN) begin
            hazard = ex_is_load &&
                     ((use_rs1 && src_hit(ex_valid, ex_rd, rf_rs1)) ||
                      (use_rs2 && src_hit(ex_valid, ex_rd, rf_rs2)));
        end else begin
            hazard = (use_rs1 && (src_hit(ex_valid, ex_rd, rf_rs1) ||
                                  src_hit(mem_valid, mem_rd, rf_rs1) ||
                                  src_hit(wb_write, wb_rd, rf_rs1))) ||
                     (use_rs2 && (src_hit(ex_valid, ex_rd, rf_rs2) ||
                                  src_hit(mem_valid, mem_rd, rf_rs2) ||
                                  src_hit(wb_write, wb_rd, rf_rs2)));
        end
    end

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            q.pc      <= in_pc;
            q.rs1_val <= use_rs1 ? rs1_val : '0;
            q.rs2_val <= use_rs2 ? rs2_val : '0;
            q.imm     <= imm;
            q.rd      <= has_rd ? in_instr[11:7] : 5'd0;
            q.opclass <= opclass;
            q.funct   <= {in_instr[30], in_instr[14:12]};
            q.illegal <= (opclass == OPC_ILLEGAL);
            out_valid <= 1'b1;
        end else if (flush || out_ready || !out_valid) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pc      = q.pc;
    assign out_rs1_val = q.rs1_val;
    assign out_rs2_val = q.rs2_val;
    assign out_imm     = q.imm;
    assign out_rd      = q.rd;
    assign out_opclass = q.opclass;
    assign out_funct   = q.funct;
    assign out_illegal = q.illegal;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: hand-computed vectors for decode, bypass, stall, flush.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic [3:0]  out_opclass, out_funct;
    logic        out_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_opclass(out_opclass), .out_funct(out_funct),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        rf_rs1_data = d1;
        rf_rs2_data = d2;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h40;
        rf_rs1_data = 0; rf_rs2_data = 0;
        ex_valid = 0; ex_rd = 0; ex_data = 0; ex_is_load = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        wb_write = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 1'b1;

        // Reset held with a valid instruction pending
        step(); step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // ADD x3,x1,x2
        present(32'h002081B3, 32'h100, 32'd5, 32'd7);
        #1;
        chk("add_rf_rs1", {27'b0, rf_rs1}, 32'd1);
        chk("add_rf_rs2", {27'b0, rf_rs2}, 32'd2);
        step();
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_rs1", out_rs1_val, 32'd5);
        chk("add_rs2", out_rs2_val, 32'd7);
        chk("add_rd", {27'b0, out_rd}, 32'd3);
        chk("add_opclass", {28'b0, out_opclass}, 32'd0);
        chk("add_pc", out_pc, 32'h100);

        // ADDI x5,x1,-1 with bypass priority EX > MEM > WB
        present(32'hFFF08293, 32'h104, 32'h11, 32'h0);
        ex_valid = 1; ex_rd = 1; ex_data = 32'hAA;
        mem_valid = 1; mem_rd = 1; mem_data = 32'hBB;
        wb_write = 1; wb_rd = 1; wb_data = 32'hCC;
        step();
        chk("byp_ex", out_rs1_val, 32'hAA);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_rd", {27'b0, out_rd}, 32'd5);
        chk("addi_opclass", {28'b0, out_opclass}, 32'd1);
        ex_valid = 0;
        step();
        chk("byp_mem", out_rs1_val, 32'hBB);
        mem_valid = 0;
        step();
        chk("byp_wb", out_rs1_val, 32'hCC);
        wb_write = 0;
        step();
        chk("byp_none_rf", out_rs1_val, 32'h11);

        // Load-use: SW x2,8(x4) behind a load to x2
        present(32'h00222423, 32'h200, 32'h1000, 32'h7);
        ex_valid = 1; ex_rd = 2; ex_is_load = 1; ex_data = 32'hDEAD;
        #1;
        chk("lu_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("lu_bubble", {31'b0, out_valid}, 32'd0);
        ex_valid = 0; ex_is_load = 0;
        mem_valid = 1; mem_rd = 2; mem_data = 32'h55;
        #1;
        chk("lu_ready_again", {31'b0, in_ready}, 32'd1);
        step();
        chk("lu_valid", {31'b0, out_valid}, 32'd1);
        chk("lu_rs2", out_rs2_val, 32'h55);
        chk("lu_rs1", out_rs1_val, 32'h1000);
        chk("sw_imm", out_imm, 32'd8);
        chk("sw_rd", {27'b0, out_rd}, 32'd0);
        chk("sw_opclass", {28'b0, out_opclass}, 32'd3);
        chk("sw_funct", {28'b0, out_funct}, 32'd2);
        mem_valid = 0;

        // x0 never forwarded, even from a WB write to x0
        present(32'h00000033, 32'h204, 32'h1234, 32'h5678);
        wb_write = 1; wb_rd = 0; wb_data = 32'hFFFF;
        step();
        chk("x0_rs1", out_rs1_val, 32'd0);
        chk("x0_rs2", out_rs2_val, 32'd0);
        chk("x0_rd", {27'b0, out_rd}, 32'd0);
        wb_write = 0;

        // LUI x7,0x12345
        present(32'h123453B7, 32'h208, 0, 0);
        step();
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", {27'b0, out_rd}, 32'd7);
        chk("lui_opclass", {28'b0, out_opclass}, 32'd7);

        // BEQ x0,x0,-4
        present(32'hFE000EE3, 32'h20C, 0, 0);
        step();
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_rd", {27'b0, out_rd}, 32'd0);
        chk("beq_opclass", {28'b0, out_opclass}, 32'd4);

        // Illegal opcode passes as valid with rd=0
        present(32'h0000047F, 32'h210, 0, 0);
        step();
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_flag", {31'b0, out_illegal}, 32'd1);
        chk("ill_rd", {27'b0, out_rd}, 32'd0);
        chk("ill_opclass", {28'b0, out_opclass}, 32'd9);

        // Backpressure for 3 cycles, then flush
        present(32'hFFF08293, 32'h300, 32'h9, 0);
        step();
        chk("bp_load_pc", out_pc, 32'h300);
        out_ready = 1'b0;
        present(32'h002081B3, 32'h400, 32'd5, 32'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            step();
            chk("bp_valid_hold", {31'b0, out_valid}, 32'd1);
            chk("bp_pc_hold", out_pc, 32'h300);
            chk("bp_rs1_hold", out_rs1_val, 32'h9);
        end
        flush = 1'b1;
        #1;
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_pending_taken_valid", {31'b0, out_valid}, 32'd1);
        chk("fl_pending_taken_pc", out_pc, 32'h400);
        chk("fl_pending_rd", {27'b0, out_rd}, 32'd3);

        // Reset mid-handshake drops the in-flight instruction
        present(32'h002081B3, 32'h500, 32'd5, 32'd7);
        rst_n = 1'b0;
        step();
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_pc", out_pc, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
